// File: rtl/tetris_input_pkg.sv
// Shared scancodes, decoder states and key-map helpers for the PS/2 game-key front end.
package tetris_input_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_SPACE = 8'h29;

  localparam int unsigned KEY_N      = 5;
  localparam int unsigned KEY_LEFT   = 0;
  localparam int unsigned KEY_RIGHT  = 1;
  localparam int unsigned KEY_DOWN   = 2;
  localparam int unsigned KEY_ROTATE = 3;
  localparam int unsigned KEY_DROP   = 4;

  localparam int unsigned FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXTBRK
  } kbd_state_t;

  // One-hot level mask for a code; the extended flag must match the map entry.
  function automatic logic [KEY_N-1:0] key_mask(input logic [7:0] code, input logic ext);
    logic [KEY_N-1:0] m;
    m = '0;
    if (ext) begin
      case (code)
        SC_LEFT:  m[KEY_LEFT]   = 1'b1;
        SC_RIGHT: m[KEY_RIGHT]  = 1'b1;
        SC_DOWN:  m[KEY_DOWN]   = 1'b1;
        SC_UP:    m[KEY_ROTATE] = 1'b1;
        default:  m = '0;
      endcase
    end else if (code == SC_SPACE) begin
      m[KEY_DROP] = 1'b1;
    end
    return m;
  endfunction

  // Keyboard status/ack bytes that carry no key event when seen outside a prefix.
  function automatic logic is_ignored(input logic [7:0] code);
    return code inside {8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host byte receiver: pin synchronisers, falling-edge sampling,
// 11-bit frame check and a mid-frame inactivity timeout.
module ps2_rx
  import tetris_input_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int unsigned TMO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned LAST_BIT = FRAME_BITS - 1;
  localparam int unsigned SHIFT_W  = FRAME_BITS - 1;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic [CNT_W-1:0]       bit_cnt;
  logic [SHIFT_W-1:0]     shift;
  logic [TMO_W-1:0]       tmo_cnt;

  logic clk_s_c;
  logic data_s_c;
  logic sample_c;
  logic frame_ok_c;

  assign clk_s_c  = clk_sync[SYNC_STAGES-1];
  assign data_s_c = data_sync[SYNC_STAGES-1];
  assign sample_c = clk_prev & ~clk_s_c;

  // shift[0] holds the start bit, shift[8:1] the data, shift[9] the parity; data_s_c is the stop bit.
  assign frame_ok_c = ~shift[0] & (^shift[SHIFT_W-1:1]) & data_s_c;

  // Pin synchronisers; reset to the idle-high line level so release never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_s_c;
    end
  end

  // Bit collection, frame check and timeout; a sample event always wins over the timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= '0;
      shift      <= '0;
      tmo_cnt    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      rx_byte    <= '0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (sample_c) begin
        tmo_cnt <= '0;
        if (bit_cnt == CNT_W'(LAST_BIT)) begin
          bit_cnt <= '0;
          if (frame_ok_c) begin
            byte_valid <= 1'b1;
            rx_byte    <= shift[8:1];
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
          shift   <= {data_s_c, shift[SHIFT_W-1:1]};
        end
      end else if (bit_cnt != '0) begin
        if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          bit_cnt   <= '0;
          tmo_cnt   <= '0;
          frame_err <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// Turns PS/2 Set-2 make/break sequences into held levels for the five game keys.
module ps2_key_tracker
  import tetris_input_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_left,
  output logic       key_right,
  output logic       key_down,
  output logic       key_rotate,
  output logic       key_drop,
  output logic       scan_valid,
  output logic [7:0] scan_code,
  output logic       frame_err
);

  kbd_state_t       state_q;
  kbd_state_t       state_d;
  logic [KEY_N-1:0] keys_q;
  logic [KEY_N-1:0] keys_d;

  ps2_rx #(
    .SYNC_STAGES    (SYNC_STAGES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_valid (scan_valid),
    .rx_byte    (scan_code),
    .frame_err  (frame_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      keys_q  <= '0;
    end else begin
      state_q <= state_d;
      keys_q  <= keys_d;
    end
  end

  // Prefix decoder; a stray E0 always resyncs to the extended-make state.
  always_comb begin
    state_d = state_q;
    keys_d  = keys_q;
    if (scan_valid) begin
      case (state_q)
        IDLE: begin
          if (scan_code == SC_EXT) begin
            state_d = EXT;
          end else if (scan_code == SC_BRK) begin
            state_d = BRK;
          end else if (!is_ignored(scan_code)) begin
            keys_d = keys_q | key_mask(scan_code, 1'b0);
          end
        end
        EXT: begin
          if (scan_code == SC_BRK) begin
            state_d = EXTBRK;
          end else if (scan_code == SC_EXT) begin
            state_d = EXT;
          end else begin
            keys_d  = keys_q | key_mask(scan_code, 1'b1);
            state_d = IDLE;
          end
        end
        BRK: begin
          if (scan_code == SC_BRK) begin
            state_d = BRK;
          end else if (scan_code == SC_EXT) begin
            state_d = EXT;
          end else begin
            keys_d  = keys_q & ~key_mask(scan_code, 1'b0);
            state_d = IDLE;
          end
        end
        EXTBRK: begin
          if (scan_code == SC_BRK) begin
            state_d = EXTBRK;
          end else if (scan_code == SC_EXT) begin
            state_d = EXT;
          end else begin
            keys_d  = keys_q & ~key_mask(scan_code, 1'b1);
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign key_left   = keys_q[KEY_LEFT];
  assign key_right  = keys_q[KEY_RIGHT];
  assign key_down   = keys_q[KEY_DOWN];
  assign key_rotate = keys_q[KEY_ROTATE];
  assign key_drop   = keys_q[KEY_DROP];

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: directed scancode scenarios plus random key traffic
// checked against a prefix-flag model of the Set-2 make/break rules.
module tb_ps2_key_tracker;

  localparam int unsigned SYNC = 2;
  localparam int unsigned TMO  = 64;
  localparam int unsigned LAT  = SYNC + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       key_left, key_right, key_down, key_rotate, key_drop;
  logic       scan_valid;
  logic [7:0] scan_code;
  logic       frame_err;
  logic [4:0] dut_keys;

  int n_checks = 0;
  int n_err    = 0;

  logic [4:0] exp_keys = '0;
  logic [7:0] exp_code = '0;
  bit         m_ext    = 1'b0;
  bit         m_brk    = 1'b0;
  bit         chk_en   = 1'b0;

  ps2_key_tracker #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .key_left   (key_left),
    .key_right  (key_right),
    .key_down   (key_down),
    .key_rotate (key_rotate),
    .key_drop   (key_drop),
    .scan_valid (scan_valid),
    .scan_code  (scan_code),
    .frame_err  (frame_err)
  );

  assign dut_keys = {key_drop, key_rotate, key_down, key_right, key_left};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: key index for a code under the given extended flag, -1 if unmapped.
  function automatic int key_of(input bit ext, input logic [7:0] c);
    if (ext) begin
      case (c)
        8'h6B:   return 0;
        8'h74:   return 1;
        8'h72:   return 2;
        8'h75:   return 3;
        default: return -1;
      endcase
    end
    return (c == 8'h29) ? 4 : -1;
  endfunction

  task automatic model_byte(input logic [7:0] c);
    int idx;
    exp_code = c;
    if (c == 8'hE0) begin
      m_ext = 1'b1;
      m_brk = 1'b0;
    end else if (c == 8'hF0) begin
      m_brk = 1'b1;
    end else if (!m_ext && !m_brk &&
                 (c == 8'hE1 || c == 8'hAA || c == 8'hFA || c == 8'hEE ||
                  c == 8'hFE || c == 8'h00 || c == 8'hFF)) begin
      // status byte outside a sequence: no effect
    end else begin
      idx = key_of(m_ext, c);
      if (idx >= 0) exp_keys[idx] = !m_brk;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par);
    return {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic drive_bit(input logic v);
    ps2_data = v;
    repeat (4) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (8) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    logic [10:0] bits;
    bits = frame_bits(b, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(bits[i]);
  endtask

  // Full frame with cycle-exact check of the pulse and key-level timing around the stop bit.
  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    logic [10:0] bits;
    logic [5:0]  sv, fe;
    logic [4:0]  k3, k4;
    logic [7:0]  sc;
    logic [4:0]  old_keys;
    logic [7:0]  old_code;
    bits = frame_bits(b, bad_par);
    for (int i = 0; i < 10; i++) drive_bit(bits[i]);
    ps2_data = bits[10];
    repeat (4) @(posedge clk);
    chk_en   = 1'b0;
    old_keys = exp_keys;
    old_code = exp_code;
    #1 ps2_clk = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      sv[j] = scan_valid;
      fe[j] = frame_err;
      if (j == 3) k3 = dut_keys;
      if (j == 4) k4 = dut_keys;
    end
    sc = scan_code;
    if (!bad_par) model_byte(b);
    check("scan_valid_timing", 32'(sv), bad_par ? 32'h0 : (32'h1 << LAT));
    check("frame_err_timing", 32'(fe), bad_par ? (32'h1 << LAT) : 32'h0);
    check("keys_before_update", 32'(k3), 32'(old_keys));
    check("keys_after_update", 32'(k4), 32'(exp_keys));
    check("scan_code_after", 32'(sc), bad_par ? 32'(old_code) : 32'(b));
    chk_en = 1'b1;
    repeat (4) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat ($urandom_range(3, 20)) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0);
  endtask

  // Continuous comparison against the model outside the stop-bit windows.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("keys", 32'(dut_keys), 32'(exp_keys));
      check("scan_code", 32'(scan_code), 32'(exp_code));
      check("scan_valid_idle", 32'(scan_valid), 32'h0);
      check("frame_err_idle", 32'(frame_err), 32'h0);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 5 ms");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] rcode [5];
    bit         rext  [5];
    logic [7:0] ucode [5];
    int         cyc;
    bit         seen;
    rcode = '{8'h6B, 8'h74, 8'h72, 8'h75, 8'h29};
    rext  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    ucode = '{8'h1C, 8'h12, 8'hAA, 8'h6B, 8'h75};

    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_keys", 32'(dut_keys), 32'h0);
    check("reset_scan_code", 32'(scan_code), 32'h0);
    check("reset_scan_valid", 32'(scan_valid), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk_en = 1'b1;

    // 1: extended make / break of Up
    send_byte(8'hE0); send_byte(8'h75);
    check("t1_rotate_make", 32'(key_rotate), 32'h1);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    check("t1_rotate_break", 32'(key_rotate), 32'h0);

    // 2: typematic Space
    for (int i = 0; i < 5; i++) begin
      send_byte(8'h29);
      check("t2_drop_held", 32'(key_drop), 32'h1);
    end
    send_byte(8'hF0); send_byte(8'h29);
    check("t2_drop_release", 32'(key_drop), 32'h0);

    // 3: keypad-4 vs Left arrow
    send_byte(8'h6B); send_byte(8'hF0); send_byte(8'h6B);
    check("t3_kp4_left", 32'(key_left), 32'h0);
    check("t3_kp4_code", 32'(scan_code), 32'h6B);
    send_byte(8'hE0); send_byte(8'h6B);
    check("t3_left_make", 32'(key_left), 32'h1);

    // 4: bad parity frame dropped, then normal decode
    send_frame(8'h1C, 1'b1);
    check("t4_code_kept", 32'(scan_code), 32'h6B);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
    check("t4_left_break", 32'(key_left), 32'h0);

    // 5: partial frame aborted by timeout
    send_partial(8'h74, 4);
    chk_en = 1'b0;
    seen = 1'b0;
    cyc = 0;
    for (int i = 0; i < int'(TMO) + 40 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      if (frame_err) seen = 1'b1;
      if (scan_valid) check("t5_no_scan_valid", 32'(scan_valid), 32'h0);
    end
    check("t5_timeout_seen", 32'(seen), 32'h1);
    check("t5_timeout_not_early", 32'(cyc >= int'(TMO) - 20), 32'h1);
    @(negedge clk);
    check("t5_timeout_pulse_len", 32'(frame_err), 32'h0);
    chk_en = 1'b1;
    repeat (4) @(posedge clk); #1;
    send_byte(8'hE0); send_byte(8'h74);
    check("t5_right_make", 32'(key_right), 32'h1);

    // 6: simultaneous holds, release one, then reset mid-frame
    send_byte(8'hE0); send_byte(8'h6B);
    send_byte(8'hE0); send_byte(8'h72);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
    check("t6_left_released", 32'(key_left), 32'h0);
    check("t6_down_held", 32'(key_down), 32'h1);
    send_byte(8'hE0);
    send_partial(8'h29, 5);
    chk_en = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t6_rst_keys", 32'(dut_keys), 32'h0);
    check("t6_rst_code", 32'(scan_code), 32'h0);
    exp_keys = '0; exp_code = '0; m_ext = 1'b0; m_brk = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk_en = 1'b1;
    send_byte(8'hE0); send_byte(8'h74);
    check("t6_after_rst_right", 32'(key_right), 32'h1);

    // Random traffic
    for (int n = 0; n < 45; n++) begin
      int  k;
      bit  brk;
      int  reps;
      k    = $urandom_range(0, 6);
      brk  = 1'($urandom_range(0, 1));
      reps = brk ? 1 : $urandom_range(1, 3);
      if (k == 6) begin
        send_frame(8'($urandom), 1'b1);
      end else begin
        for (int r = 0; r < reps; r++) begin
          if (k < 5 && rext[k]) send_byte(8'hE0);
          if (brk) send_byte(8'hF0);
          send_byte(k < 5 ? rcode[k] : ucode[$urandom_range(0, 4)]);
        end
      end
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
